// File: rtl/uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_cfg
// Purpose  : Runtime-configurable UART transmitter with a small input FIFO.
//            Programmable baud divisor, 5-8 data bits, optional parity and
//            1 or 2 stop bits. Queued frames are sent back-to-back with no
//            idle gap between them.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            cfg_div             - clocks per bit (0 and 1 both mean 1)
//            cfg_data_bits       - 0..3 -> 5..8 data bits
//            cfg_parity          - 00/11 none, 01 even, 10 odd
//            cfg_stop2           - 1 selects two stop bits
//            data_in_valid/ready - byte write handshake into the FIFO
//            data_in             - byte, LSB transmitted first
//            serial_out          - TX line, idles high
//            busy                - frame in progress or FIFO non-empty
//            fifo_count          - occupied FIFO entries
// Config   : define UART_TX_PARITY_EN to build the parity stage; without it
//            cfg_parity is ignored and frames carry no parity bit.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_cfg #(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DIV_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DIV_WIDTH-1:0]        cfg_div,
    input  logic [1:0]                  cfg_data_bits,
    input  logic [1:0]                  cfg_parity,
    input  logic                        cfg_stop2,
    input  logic                        data_in_valid,
    output logic                        data_in_ready,
    input  logic [7:0]                  data_in,
    output logic                        serial_out,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_CW = c_AW + 1;

    localparam logic [c_CW-1:0]      c_FULL      = c_CW'(FIFO_DEPTH);
    localparam logic [c_CW-1:0]      c_CNT_ONE   = c_CW'(1);
    localparam logic [c_AW-1:0]      c_PTR_ONE   = c_AW'(1);
    localparam logic [DIV_WIDTH-1:0] c_DIV_ONE   = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] c_RESET_DIV = DIV_WIDTH'(CLOCK_FREQ / BAUD_RATE);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] c_ST_PARITY = 3'd4;
`endif

    // ------------------------------------------------------------------
    // Input FIFO
    // ------------------------------------------------------------------
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic            w_push;
    logic            w_pop;
    logic            w_fifo_nempty;
    logic [7:0]      w_head;

    // Ready depends only on occupancy, so a full FIFO refuses a push even
    // when the transmitter pops in the same cycle.
    assign data_in_ready = (r_count != c_FULL);
    assign w_push        = data_in_valid && data_in_ready;
    assign w_fifo_nempty = (r_count != '0);
    assign w_head        = r_mem[r_rd_ptr];
    assign fifo_count    = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    logic [2:0]           r_state;
    logic [DIV_WIDTH-1:0] r_baud_cnt;
    logic [DIV_WIDTH-1:0] r_div;
    logic [2:0]           r_bit_cnt;
    logic [2:0]           r_last_data;
    logic                 r_stop2;
    logic [7:0]           r_shift;
    logic                 r_tx;
    logic                 w_tx_next;
    logic                 w_bit_end;
    logic                 w_frame_end;
    logic [DIV_WIDTH-1:0] w_div_eff;

    assign w_div_eff   = (cfg_div <= c_DIV_ONE) ? c_DIV_ONE : cfg_div;
    assign w_bit_end   = (r_baud_cnt == (r_div - c_DIV_ONE));
    // r_bit_cnt counts stop bits while in STOP: last stop bit is index stop2.
    assign w_frame_end = (r_state == c_ST_STOP) && w_bit_end &&
                         (r_bit_cnt == {2'b00, r_stop2});
    // Pop from IDLE, or on the final clock of a frame so the next frame
    // starts without an idle cycle.
    assign w_pop       = w_fifo_nempty && ((r_state == c_ST_IDLE) || w_frame_end);

`ifdef UART_TX_PARITY_EN
    logic       r_par_en;
    logic       r_par_bit;
    logic [7:0] w_mask;
    logic       w_load_par;

    always_comb begin
        w_mask = 8'hFF;
        case (cfg_data_bits)
            2'd0:    w_mask = 8'h1F;
            2'd1:    w_mask = 8'h3F;
            2'd2:    w_mask = 8'h7F;
            default: w_mask = 8'hFF;
        endcase
    end

    // Parity is computed once at load time from the masked byte.
    assign w_load_par = (^(w_head & w_mask)) ^ (cfg_parity == 2'b10);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
        end else if (w_pop) begin
            r_par_en  <= ^cfg_parity;
            r_par_bit <= w_load_par;
        end
    end
`else
    logic w_unused_parity;
    assign w_unused_parity = ^cfg_parity;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_baud_cnt  <= '0;
            r_div       <= c_RESET_DIV;
            r_bit_cnt   <= '0;
            r_last_data <= 3'd7;
            r_stop2     <= 1'b0;
            r_shift     <= '0;
        end else if (w_pop) begin
            // Frame configuration is frozen here for the whole frame.
            r_state     <= c_ST_START;
            r_baud_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_div       <= w_div_eff;
            r_last_data <= {1'b0, cfg_data_bits} + 3'd4;
            r_stop2     <= cfg_stop2;
            r_shift     <= w_head;
        end else begin
            if (r_state != c_ST_IDLE) begin
                r_baud_cnt <= w_bit_end ? '0 : r_baud_cnt + c_DIV_ONE;
            end
            case (r_state)
                c_ST_START: begin
                    if (w_bit_end) begin
                        r_state <= c_ST_DATA;
                    end
                end
                c_ST_DATA: begin
                    if (w_bit_end) begin
                        r_shift <= {1'b0, r_shift[7:1]};
                        if (r_bit_cnt == r_last_data) begin
                            r_bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                            r_state   <= r_par_en ? c_ST_PARITY : c_ST_STOP;
`else
                            r_state   <= c_ST_STOP;
`endif
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                c_ST_PARITY: begin
                    if (w_bit_end) begin
                        r_state <= c_ST_STOP;
                    end
                end
`endif
                c_ST_STOP: begin
                    if (w_bit_end) begin
                        if (r_bit_cnt == {2'b00, r_stop2}) begin
                            r_bit_cnt <= '0;
                            r_state   <= c_ST_IDLE;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                end
                c_ST_IDLE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_tx_next = 1'b1;
        case (r_state)
            c_ST_START:  w_tx_next = 1'b0;
            c_ST_DATA:   w_tx_next = r_shift[0];
`ifdef UART_TX_PARITY_EN
            c_ST_PARITY: w_tx_next = r_par_bit;
`endif
            default:     w_tx_next = 1'b1;
        endcase
    end

    // Registered line driver: glitch-free pin, and the async reset forces
    // the line high immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx <= 1'b1;
        end else begin
            r_tx <= w_tx_next;
        end
    end

    assign serial_out = r_tx;
    assign busy       = (r_state != c_ST_IDLE) || w_fifo_nempty;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_cfg
// Purpose  : Self-checking bench for uart_tx_cfg. Expected line samples are
//            queued per clock when a byte is pushed and compared against
//            serial_out as the frame is transmitted.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_cfg;

    localparam int DIV_WIDTH  = 16;
    localparam int FIFO_DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [DIV_WIDTH-1:0] cfg_div = 16'd4;
    logic [1:0]           cfg_data_bits = 2'd3;
    logic [1:0]           cfg_parity = 2'd0;
    logic                 cfg_stop2 = 1'b0;
    logic                 data_in_valid = 1'b0;
    logic                 data_in_ready;
    logic [7:0]           data_in = 8'h00;
    logic                 serial_out;
    logic                 busy;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    int   checks = 0;
    int   errors = 0;
    logic exp_q[$];
    bit   active = 1'b0;

    uart_tx_cfg #(
        .CLOCK_FREQ(125_000_000),
        .BAUD_RATE (115_200),
        .DIV_WIDTH (DIV_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_div      (cfg_div),
        .cfg_data_bits(cfg_data_bits),
        .cfg_parity   (cfg_parity),
        .cfg_stop2    (cfg_stop2),
        .data_in_valid(data_in_valid),
        .data_in_ready(data_in_ready),
        .data_in      (data_in),
        .serial_out   (serial_out),
        .busy         (busy),
        .fifo_count   (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference frame: per-clock line values for one byte.
    task automatic enq_frame(input logic [7:0] d, input int div, input int bits,
                             input logic [1:0] par, input logic stop2);
        int   dv;
        int   n;
        logic p;
        dv = (div < 2) ? 1 : div;
        n  = bits + 5;
        p  = 1'b0;
        repeat (dv) exp_q.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            p = p ^ d[i];
            repeat (dv) exp_q.push_back(d[i]);
        end
        if (PAR_EN && (par == 2'b01 || par == 2'b10)) begin
            repeat (dv) exp_q.push_back((par == 2'b10) ? ~p : p);
        end
        repeat ((stop2 ? 2 : 1) * dv) exp_q.push_back(1'b1);
    endtask

    task automatic enq_cur(input logic [7:0] d);
        enq_frame(d, int'(cfg_div), int'(cfg_data_bits), cfg_parity, cfg_stop2);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Push one byte; returns one tick after the accepting edge.
    task automatic push_one(input logic [7:0] d);
        data_in       = d;
        data_in_valid = 1'b1;
        enq_cur(d);
        tick(1);
        data_in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        chk("drain", exp_q.size(), 0);
        exp_q.delete();
        active = 1'b0;
        tick(3);
    endtask

    // Line monitor: once a start bit appears, consume one expected sample
    // per clock; when nothing is expected the line must stay idle high.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (exp_q.size() != 0 && (active || serial_out == 1'b0)) begin
                    active = 1'b1;
                    chk("line", serial_out, exp_q.pop_front());
                    if (exp_q.size() == 0) active = 1'b0;
                end else if (exp_q.size() == 0) begin
                    chk("idle", serial_out, 1);
                end
            end
        end
    end

    logic [7:0] burst [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    int         burst_cnt [5] = '{1, 1, 2, 3, 4};

    initial begin
        // Reset values
        tick(2);
        chk("rst_serial", serial_out, 1);
        chk("rst_count", fifo_count, 0);
        chk("rst_ready", data_in_ready, 1);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick(2);
        chk("post_rst_busy", busy, 0);

        // 8N1, div 4, 0xA5
        cfg_div = 16'd4; cfg_data_bits = 2'd3; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
        push_one(8'hA5);
        chk("t1_count_push", fifo_count, 1);
        chk("t1_busy_push", busy, 1);
        chk("t1_line_e0", serial_out, 1);
        tick(1);
        chk("t1_line_e1", serial_out, 1);
        chk("t1_count_pop", fifo_count, 0);
        tick(1);
        chk("t1_line_e2", serial_out, 0);
        tick(38);
        chk("t1_busy_e40", busy, 1);
        tick(1);
        chk("t1_busy_e41", busy, 0);
        wait_drain(20);

        // 7-bit, parity, 2 stop, div 3
        cfg_div = 16'd3; cfg_data_bits = 2'd2; cfg_parity = 2'b01; cfg_stop2 = 1'b1;
        push_one(8'h53);
        wait_drain(60);
        cfg_parity = 2'b10;
        push_one(8'h53);
        wait_drain(60);
        cfg_parity = 2'b00; cfg_stop2 = 1'b0; cfg_data_bits = 2'd3;

        // FIFO fill with valid held high, div 2
        cfg_div = 16'd2;
        data_in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            int n;
            data_in = burst[i];
            n = 0;
            while (!data_in_ready && n < 200) begin
                tick(1);
                n++;
            end
            enq_cur(burst[i]);
            tick(1);
            chk("t3_count_push", fifo_count, burst_cnt[i]);
        end
        data_in_valid = 1'b0;
        chk("t3_ready_full", data_in_ready, 0);
        tick(16);
        chk("t3_count_e20", fifo_count, 4);
        tick(1);
        chk("t3_count_e21", fifo_count, 3);
        chk("t3_ready_e21", data_in_ready, 1);
        wait_drain(200);

        // Mid-frame config change
        cfg_div = 16'd4; cfg_data_bits = 2'd3;
        push_one(8'hC3);
        tick(10);
        cfg_div = 16'd8; cfg_data_bits = 2'd0;
        push_one(8'h1D);
        wait_drain(200);
        cfg_data_bits = 2'd3;

        // Reset mid-DATA with two bytes queued
        cfg_div = 16'd4;
        push_one(8'h00);
        push_one(8'hFF);
        push_one(8'hFF);
        tick(12);
        chk("t5_line_data", serial_out, 0);
        chk("t5_count_q", fifo_count, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_line", serial_out, 1);
        chk("t5_rst_count", fifo_count, 0);
        chk("t5_rst_busy", busy, 0);
        exp_q.delete();
        active = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        chk("t5_rel_count", fifo_count, 0);
        chk("t5_rel_busy", busy, 0);
        tick(60);
        chk("t5_still_idle_busy", busy, 0);

        // Divisor 0 and 1 -> 1 clock per bit, 5N1
        cfg_div = 16'd0; cfg_data_bits = 2'd0; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
        push_one(8'h15);
        wait_drain(30);
        cfg_div = 16'd1;
        push_one(8'h0A);
        wait_drain(30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
